// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//
// Timing and data-staging stage in front of the 4-digit seven-segment display
// driver. A free-running divider produces the digit scan index and the blink
// clock. Display contents written by the CPU are staged and committed only at
// a frame boundary, so one frame never mixes old and new digits.
//
// Parameters
//   SCAN_LSB   divider bit of Scanning[0]; each digit is driven 2^SCAN_LSB cycles
//   FLASH_BIT  divider bit driving flash_clk; must be > SCAN_LSB+1
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   load        single-cycle request to update display contents
//   num_in      new display value (8 nibbles / 4 digits as the driver expects)
//   point_in    new decimal-point mask, active-low per digit
//   blink_in    new blink mask, 1 = digit blinks
//   disp_num    committed display value
//   pointing    committed decimal-point mask
//   blinking    committed blink mask
//   Scanning    current digit index
//   flash_clk   blink clock
//   frame_tick  one-cycle pulse on the last cycle of each frame
//   pending     a staged update is waiting for the frame boundary
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int SCAN_LSB  = 16,
    parameter int FLASH_BIT = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] num_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  blink_in,
    output logic [31:0] disp_num,
    output logic [3:0]  pointing,
    output logic [3:0]  blinking,
    output logic [1:0]  Scanning,
    output logic        flash_clk,
    output logic        frame_tick,
    output logic        pending
);

    localparam int DIV_W = FLASH_BIT + 1;

    // Reset values of the committed display state: blank value, all dots off
    // (active-low), no blinking.
    localparam logic [31:0] NUM_RST   = 32'h0000_0000;
    localparam logic [3:0]  POINT_RST = 4'b1111;
    localparam logic [3:0]  BLINK_RST = 4'b0000;

    logic [DIV_W-1:0] div;
    logic             frame_end;

    logic [31:0] stg_num,  stg_num_nxt;
    logic [3:0]  stg_point, stg_point_nxt;
    logic [3:0]  stg_blink, stg_blink_nxt;
    logic        pending_nxt;

    logic [31:0] disp_num_nxt;
    logic [3:0]  pointing_nxt;
    logic [3:0]  blinking_nxt;

    // -------------------------------------------------------------------------
    // Free-running divider and its decodes
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Last cycle of digit 3: every bit up to and including the scan index is 1.
    assign frame_end  = &div[SCAN_LSB+1:0];
    assign frame_tick = frame_end;
    assign Scanning   = div[SCAN_LSB+1:SCAN_LSB];
    assign flash_clk  = div[FLASH_BIT];

    // -------------------------------------------------------------------------
    // Staging / commit next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a hold value first, so no path through
    // the if/else chain can leave one unassigned and infer a latch.
    always_comb begin
        stg_num_nxt   = stg_num;
        stg_point_nxt = stg_point;
        stg_blink_nxt = stg_blink;
        pending_nxt   = pending;
        disp_num_nxt  = disp_num;
        pointing_nxt  = pointing;
        blinking_nxt  = blinking;

        if (load && frame_end) begin
            // Newest data wins and goes straight out; any staged value is dropped.
            disp_num_nxt = num_in;
            pointing_nxt = point_in;
            blinking_nxt = blink_in;
            pending_nxt  = 1'b0;
        end else if (load) begin
            // Mid-frame write: overwrite staging (last write wins) and wait.
            stg_num_nxt   = num_in;
            stg_point_nxt = point_in;
            stg_blink_nxt = blink_in;
            pending_nxt   = 1'b1;
        end else if (frame_end && pending) begin
            disp_num_nxt = stg_num;
            pointing_nxt = stg_point;
            blinking_nxt = stg_blink;
            pending_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_num   <= '0;
            stg_point <= POINT_RST;
            stg_blink <= BLINK_RST;
            pending   <= 1'b0;
            disp_num  <= NUM_RST;
            pointing  <= POINT_RST;
            blinking  <= BLINK_RST;
        end else begin
            stg_num   <= stg_num_nxt;
            stg_point <= stg_point_nxt;
            stg_blink <= stg_blink_nxt;
            pending   <= pending_nxt;
            disp_num  <= disp_num_nxt;
            pointing  <= pointing_nxt;
            blinking  <= blinking_nxt;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
//
// Scoreboard bench for disp_scan_ctrl with SCAN_LSB=2, FLASH_BIT=5 (16-cycle
// frame, 64-cycle flash period). Every load pushes the update it should cause,
// tagged with the cycle at which it must become visible, into a queue. A
// monitor on the falling edge retires due updates and compares all outputs
// against values derived from the cycle count since reset.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] num_in = '0;
    logic [3:0]  point_in = '0;
    logic [3:0]  blink_in = '0;
    logic [31:0] disp_num;
    logic [3:0]  pointing;
    logic [3:0]  blinking;
    logic [1:0]  Scanning;
    logic        flash_clk;
    logic        frame_tick;
    logic        pending;

    disp_scan_ctrl #(
        .SCAN_LSB (2),
        .FLASH_BIT(5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .num_in    (num_in),
        .point_in  (point_in),
        .blink_in  (blink_in),
        .disp_num  (disp_num),
        .pointing  (pointing),
        .blinking  (blinking),
        .Scanning  (Scanning),
        .flash_clk (flash_clk),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Cycle number since reset release; cycle t is the interval in which the
    // divider holds t (mod its period).
    int t = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    // ---------------------------------------------------------------- model
    typedef struct {
        int          load_cyc;    // cycle the (first) still-pending load was issued
        int          commit_cyc;  // first cycle the value must be visible
        logic [31:0] num;
        logic [3:0]  pt;
        logic [3:0]  bl;
    } upd_t;

    upd_t        sb_q[$];
    logic [31:0] e_num = 32'h0;
    logic [3:0]  e_pt  = 4'hF;
    logic [3:0]  e_bl  = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        e_num = 32'h0;
        e_pt  = 4'hF;
        e_bl  = 4'h0;
    endtask

    // A load in cycle t becomes visible at the start of the next frame.
    task automatic do_load(input logic [31:0] n, input logic [3:0] p, input logic [3:0] b);
        upd_t u;
        int   c;
        c = (t / FRAME + 1) * FRAME;
        num_in   = n;
        point_in = p;
        blink_in = b;
        load     = 1'b1;
        u.load_cyc   = t;
        u.commit_cyc = c;
        u.num        = n;
        u.pt         = p;
        u.bl         = b;
        // A second write inside the same frame replaces the first; the flag
        // has been up since the first write.
        if (sb_q.size() > 0 && sb_q[$].commit_cyc == c) begin
            u.load_cyc = sb_q[$].load_cyc;
            void'(sb_q.pop_back());
        end
        sb_q.push_back(u);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // One-cycle reset pulse with a load driven concurrently (must be ignored).
    task automatic do_reset();
        rst      = 1'b1;
        load     = 1'b1;
        num_in   = $urandom;
        point_in = 4'($urandom);
        blink_in = 4'($urandom);
        model_reset();
        @(posedge clk); #1;
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic goto(input int target);
        for (int i = 0; i < 4000 && t != target; i++) idle();
        n_cmp++;
        if (t != target) begin
            n_bad++;
            $display("FAIL goto: cycle %0d reached, wanted %0d", t, target);
        end
    endtask

    // -------------------------------------------------------------- monitor
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].commit_cyc <= t) begin
            e_num = sb_q[0].num;
            e_pt  = sb_q[0].pt;
            e_bl  = sb_q[0].bl;
            void'(sb_q.pop_front());
        end
        check("disp_num",   disp_num,          e_num);
        check("pointing",   32'(pointing),     32'(e_pt));
        check("blinking",   32'(blinking),     32'(e_bl));
        check("Scanning",   32'(Scanning),     32'((t / 4) % 4));
        check("flash_clk",  32'(flash_clk),    32'((t / 32) % 2));
        check("frame_tick", 32'(frame_tick),   32'(t % FRAME == FRAME - 1));
        check("pending",    32'(pending),
              32'(sb_q.size() > 0 && sb_q[0].load_cyc < t));
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Free run through one flash period.
        goto(64);

        // Single mid-frame load.
        do_reset();
        goto(5);
        do_load(32'h1234ABCD, 4'b1011, 4'b0001);
        goto(20);

        // Two loads in one frame: only the second is ever shown.
        do_reset();
        goto(3);
        do_load(32'hAAAA0000, 4'b0000, 4'b1111);
        goto(9);
        do_load(32'h5555FFFF, 4'b0101, 4'b1010);
        goto(20);

        // Load on frame_end while an older value is pending.
        do_reset();
        goto(3);
        do_load(32'h0BAD0BAD, 4'b1110, 4'b0110);
        goto(15);
        do_load(32'hDEADBEEF, 4'b0111, 4'b1000);
        goto(20);

        // Reset while an update is pending: it must never commit.
        do_reset();
        goto(20);
        do_load(32'hCAFEF00D, 4'b0000, 4'b1111);
        goto(25);
        do_reset();
        goto(40);

        // Divider wrap with a load just before it.
        do_reset();
        goto(126);
        do_load(32'h600DD00D, 4'b1001, 4'b0011);
        goto(140);

        // Random loads, with occasional back-to-back writes and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0)     do_reset();
            else if ($urandom_range(0, 5) == 0)  do_load($urandom, 4'($urandom), 4'($urandom));
            else                                 idle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
